// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit sequencer state encoding and default byte constants.
`timescale 1ns/1ps
package uart_pkg;

   localparam int unsigned BYTE_W = 8;
   localparam logic [BYTE_W-1:0] HB_BYTE_DEFAULT = 8'hAA;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_GUARD = 2'd2,
      ST_DRAIN = 2'd3
   } tx_state_e;

endpackage

// File: rtl/sync_byte_fifo.sv
// Single-clock circular byte FIFO with registered full/empty/level flags.
`timescale 1ns/1ps
module sync_byte_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk_50,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [BYTE_W-1:0]        wr_data,
   input  logic                     pop,
   output logic [BYTE_W-1:0]        rd_data_c,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [BYTE_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [LW-1:0]     count_nxt;
   logic              do_push;
   logic              do_pop;

   assign do_push   = push && !full;
   assign do_pop    = pop && !empty;
   assign rd_data_c = mem[rd_ptr];

   always_comb begin
      count_nxt = level;
      if (do_push && !do_pop) begin
         count_nxt = level + LW'(1);
      end else if (!do_push && do_pop) begin
         count_nxt = level - LW'(1);
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         level <= count_nxt;
         full  <= (count_nxt == LW'(DEPTH));
         empty <= (count_nxt == LW'(0));
      end
   end

   always_ff @(posedge clk_50) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/uart_resp_queue.sv
// Response byte queue and uart_tx sequencer; inserts a coalesced heartbeat only when
// no response bytes are queued, in flight, or part of an unfinished frame.
`timescale 1ns/1ps
module uart_resp_queue
   import uart_pkg::*;
#(
   parameter int unsigned       DEPTH   = 16,
   parameter logic [BYTE_W-1:0] HB_BYTE = HB_BYTE_DEFAULT
) (
   input  logic                     clk_50,
   input  logic                     rst_n,
   input  logic                     resp_wr,
   input  logic [BYTE_W-1:0]        resp_data,
   input  logic                     resp_eof,
   output logic                     resp_full,
   output logic [$clog2(DEPTH):0]   resp_level,
   output logic                     ovf,
   input  logic                     ovf_clr,
   input  logic                     hb_tick,
   input  logic                     hb_en,
   output logic [BYTE_W-1:0]        tx_data,
   output logic                     tx_send,
   input  logic                     tx_busy
);

   tx_state_e         state;
   tx_state_e         state_nxt;
   logic [BYTE_W-1:0] tx_data_nxt;
   logic              tx_send_nxt;
   logic              pop_c;
   logic              hb_issue_c;
   logic              push_ok;
   logic              fifo_empty;
   logic [BYTE_W-1:0] fifo_rd_c;
   logic              frame_open;
   logic              hb_req_q;
   logic              hb_pending;

   assign push_ok = resp_wr && !resp_full;

   sync_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_50    (clk_50),
      .rst_n     (rst_n),
      .push      (push_ok),
      .wr_data   (resp_data),
      .pop       (pop_c),
      .rd_data_c (fifo_rd_c),
      .full      (resp_full),
      .empty     (fifo_empty),
      .level     (resp_level)
   );

   // Next-state and registered-output decode.
   always_comb begin
      state_nxt   = state;
      tx_data_nxt = tx_data;
      tx_send_nxt = 1'b0;
      pop_c       = 1'b0;
      hb_issue_c  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!tx_busy) begin
               if (!fifo_empty) begin
                  tx_data_nxt = fifo_rd_c;
                  tx_send_nxt = 1'b1;
                  pop_c       = 1'b1;
                  state_nxt   = ST_ISSUE;
               end else if (!frame_open && hb_pending) begin
                  tx_data_nxt = HB_BYTE;
                  tx_send_nxt = 1'b1;
                  hb_issue_c  = 1'b1;
                  state_nxt   = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: state_nxt = ST_GUARD;
         // uart_tx raises busy one cycle after the strobe, so it is not trusted here.
         ST_GUARD: state_nxt = ST_DRAIN;
         ST_DRAIN: begin
            if (!tx_busy) state_nxt = ST_IDLE;
         end
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         tx_data <= '0;
         tx_send <= 1'b0;
      end else begin
         state   <= state_nxt;
         tx_data <= tx_data_nxt;
         tx_send <= tx_send_nxt;
      end
   end

   // Frame tracking, heartbeat coalescing and sticky overflow.
   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         frame_open <= 1'b0;
         hb_req_q   <= 1'b0;
         hb_pending <= 1'b0;
         ovf        <= 1'b0;
      end else begin
         if (push_ok) frame_open <= !resp_eof;
         hb_req_q <= hb_tick && hb_en;
         if (!hb_en) begin
            hb_pending <= 1'b0;
         end else if (hb_req_q) begin
            hb_pending <= 1'b1;
         end else if (hb_issue_c) begin
            hb_pending <= 1'b0;
         end
         if (resp_wr && resp_full) begin
            ovf <= 1'b1;
         end else if (ovf_clr) begin
            ovf <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_resp_queue.sv
// Scoreboard bench for uart_resp_queue: expected tx bytes are queued at stimulus time
// and compared by an independent monitor on every tx_send strobe.
`timescale 1ns/1ps
module tb_uart_resp_queue;
   import uart_pkg::*;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned LW    = $clog2(DEPTH) + 1;

   logic          clk_50 = 1'b0;
   logic          rst_n;
   logic          resp_wr;
   logic [7:0]    resp_data;
   logic          resp_eof;
   logic          resp_full;
   logic [LW-1:0] resp_level;
   logic          ovf;
   logic          ovf_clr;
   logic          hb_tick;
   logic          hb_en;
   logic [7:0]    tx_data;
   logic          tx_send;
   logic          tx_busy;

   int checks = 0;
   int errors = 0;
   int sends  = 0;
   logic [7:0] exp_q[$];
   logic [7:0] mon_exp;

   logic busy_hold;
   int   busy_len;
   int   bcnt;

   always #10 clk_50 = ~clk_50;

   uart_resp_queue #(.DEPTH(DEPTH), .HB_BYTE(8'hAA)) dut (
      .clk_50     (clk_50),
      .rst_n      (rst_n),
      .resp_wr    (resp_wr),
      .resp_data  (resp_data),
      .resp_eof   (resp_eof),
      .resp_full  (resp_full),
      .resp_level (resp_level),
      .ovf        (ovf),
      .ovf_clr    (ovf_clr),
      .hb_tick    (hb_tick),
      .hb_en      (hb_en),
      .tx_data    (tx_data),
      .tx_send    (tx_send),
      .tx_busy    (tx_busy)
   );

   // Transmitter model: busy rises one cycle after the strobe and lasts busy_len cycles.
   always @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) bcnt <= 0;
      else if (tx_send) bcnt <= busy_len + 1;
      else if (bcnt != 0) bcnt <= bcnt - 1;
   end
   assign tx_busy = busy_hold | ((bcnt != 0) && (bcnt <= busy_len));

   always @(negedge clk_50) begin
      if (rst_n && tx_send) begin
         sends++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_send got %02h required no send", tx_data);
         end else begin
            mon_exp = exp_q.pop_front();
            if (tx_data !== mon_exp) begin
               errors++;
               $display("FAIL tx_byte got %02h required %02h", tx_data, mon_exp);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h required %0h", nm, act, exp);
      end
   endtask

   task automatic push_byte(input logic [7:0] d, input logic eof);
      resp_wr   = 1'b1;
      resp_data = d;
      resp_eof  = eof;
      @(posedge clk_50); #1;
      resp_wr   = 1'b0;
      resp_eof  = 1'b0;
   endtask

   task automatic pulse_tick();
      hb_tick = 1'b1;
      @(posedge clk_50); #1;
      hb_tick = 1'b0;
   endtask

   task automatic wait_drain(input string nm);
      int n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         @(negedge clk_50);
         n++;
      end
      chk({nm, "_drain_left"}, 32'(exp_q.size()), 32'd0);
      repeat (30) @(posedge clk_50);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0;
      int n;
      int guard;
      logic [7:0] d;

      rst_n = 1'b0; resp_wr = 1'b0; resp_data = 8'h00; resp_eof = 1'b0;
      ovf_clr = 1'b0; hb_tick = 1'b0; hb_en = 1'b1;
      busy_hold = 1'b0; busy_len = 0;
      #1;
      chk("rst_tx_send", 32'(tx_send), 32'd0);
      chk("rst_tx_data", 32'(tx_data), 32'd0);
      chk("rst_full",    32'(resp_full), 32'd0);
      chk("rst_level",   32'(resp_level), 32'd0);
      chk("rst_ovf",     32'(ovf), 32'd0);
      repeat (3) @(posedge clk_50);
      #1 rst_n = 1'b1;
      @(posedge clk_50); #1;

      // Single ping with latency checks.
      busy_len = 6;
      s0 = sends;
      exp_q.push_back(8'hEE);
      push_byte(8'hEE, 1'b1);
      @(negedge clk_50);
      chk("ping_level_e0", 32'(resp_level), 32'd1);
      chk("ping_send_e0",  32'(tx_send), 32'd0);
      @(negedge clk_50);
      chk("ping_send_e1",  32'(tx_send), 32'd1);
      chk("ping_level_e1", 32'(resp_level), 32'd0);
      wait_drain("ping");
      chk("ping_sends", 32'(sends - s0), 32'd1);

      // Heartbeat must wait for the read frame to close and drain.
      s0 = sends;
      exp_q.push_back(8'h12); exp_q.push_back(8'h34); exp_q.push_back(8'hAA);
      push_byte(8'h12, 1'b0);
      pulse_tick();
      push_byte(8'h34, 1'b1);
      wait_drain("frame");
      chk("frame_sends", 32'(sends - s0), 32'd3);

      // Coalescing under held busy.
      s0 = sends;
      busy_hold = 1'b1;
      repeat (5) begin
         pulse_tick();
         @(posedge clk_50); #1;
      end
      repeat (10) @(posedge clk_50);
      #1;
      chk("coal_quiet", 32'(sends - s0), 32'd0);
      exp_q.push_back(8'hAA);
      busy_hold = 1'b0;
      wait_drain("coal");
      chk("coal_sends", 32'(sends - s0), 32'd1);

      // Heartbeat disabled.
      hb_en = 1'b0;
      s0 = sends;
      pulse_tick();
      repeat (20) @(posedge clk_50);
      #1;
      chk("hboff_sends", 32'(sends - s0), 32'd0);

      // Overflow: 17 pushes against a stuck transmitter.
      busy_hold = 1'b1;
      for (int i = 0; i < 17; i++) begin
         if (i < 16) exp_q.push_back(8'(i));
         push_byte(8'(i), 1'b1);
      end
      @(negedge clk_50);
      chk("ovf_full",  32'(resp_full), 32'd1);
      chk("ovf_flag",  32'(ovf), 32'd1);
      chk("ovf_level", 32'(resp_level), 32'd16);
      s0 = sends;
      @(posedge clk_50); #1;
      busy_hold = 1'b0;
      wait_drain("ovf");
      chk("ovf_sends",  32'(sends - s0), 32'd16);
      chk("ovf_sticky", 32'(ovf), 32'd1);
      chk("ovf_empty_level", 32'(resp_level), 32'd0);
      ovf_clr = 1'b1;
      @(posedge clk_50); #1;
      ovf_clr = 1'b0;
      @(negedge clk_50);
      chk("ovf_cleared", 32'(ovf), 32'd0);

      // Random stream through the wrapping buffer, never exceeding capacity.
      @(posedge clk_50); #1;
      busy_len = 6;
      s0 = sends;
      n = 0;
      guard = 0;
      while (n < 40 && guard < 5000) begin
         guard++;
         if (exp_q.size() < DEPTH && $urandom_range(0, 2) != 0) begin
            d = 8'($urandom);
            exp_q.push_back(d);
            push_byte(d, (n == 39) || ($urandom_range(0, 1) == 1));
            n++;
         end else begin
            @(posedge clk_50); #1;
         end
      end
      chk("wrap_pushed", 32'(n), 32'd40);
      wait_drain("wrap");
      chk("wrap_sends", 32'(sends - s0), 32'd40);

      // Reset during DRAIN with five bytes still queued.
      busy_len = 20;
      s0 = sends;
      for (int i = 0; i < 6; i++) begin
         exp_q.push_back(8'h51 + 8'(i));
         push_byte(8'h51 + 8'(i), 1'b1);
      end
      @(negedge clk_50);
      chk("mid_level", 32'(resp_level), 32'd5);
      chk("mid_data",  32'(tx_data), 32'h51);
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      chk("mid_rst_send",  32'(tx_send), 32'd0);
      chk("mid_rst_data",  32'(tx_data), 32'd0);
      chk("mid_rst_full",  32'(resp_full), 32'd0);
      chk("mid_rst_level", 32'(resp_level), 32'd0);
      chk("mid_rst_ovf",   32'(ovf), 32'd0);
      repeat (2) @(posedge clk_50);
      #1 rst_n = 1'b1;
      repeat (60) @(posedge clk_50);
      #1;
      chk("mid_post_sends", 32'(sends - s0), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_resp_queue.md
# uart_resp_queue

Response byte queue and transmit sequencer between the UART command parser and `uart_tx`, all in the clk_50 domain. Command responses arrive as framed byte bursts: a ping ack, a write ack, or a read response as a high byte then a low byte. They are buffered in a FIFO and issued one byte at a time over the `uart_tx` send/busy handshake. A coalesced heartbeat byte is inserted only when no response data is queued or in flight. This replaces the fixed 3-byte inline queue and allows back-to-back commands without losing responses.

## Interface
- DEPTH, 16, FIFO entries; power of two, ≥4
- HB_BYTE, 8'hAA, heartbeat byte value
- clk_50  in  1  system/UART clock
- rst_n  in  1  reset, asynchronous, active-low
- resp_wr  in  1  push resp_data this cycle
- resp_data  in  8  response byte
- resp_eof  in  1  qualifies resp_wr; byte is the last byte of its frame
- resp_full  out  1  count == DEPTH
- resp_level  out  $clog2(DEPTH)+1  current entry count
- ovf  out  1  sticky: a push was dropped while full
- ovf_clr  in  1  clears ovf
- hb_tick  in  1  one-cycle heartbeat request pulse
- hb_en  in  1  heartbeat enable, level
- tx_data  out  8  byte to `uart_tx`
- tx_send  out  1  one-cycle send strobe to `uart_tx`
- tx_busy  in  1  `uart_tx` busy

## Operation
- **FIFO.** Circular buffer with rd_ptr/wr_ptr and count.
  - Push when resp_wr && !resp_full; a push while full is dropped and sets ovf.
  - ovf_clr in the same cycle as an overflow: set wins.
  - Simultaneous push and pop: count unchanged.
  - Pointers wrap modulo DEPTH.
- **frame_open flag.**
  - Set on an accepted push with !resp_eof.
  - Cleared on an accepted push with resp_eof.
  - A dropped push leaves frame_open unchanged.
- **hb_pending flag.**
  - Set on hb_tick && hb_en; repeated ticks coalesce into one pending heartbeat.
  - Cleared when the heartbeat is issued, or when hb_en is low.
- **FSM.** Registered outputs; states IDLE, ISSUE, GUARD, DRAIN.
  - IDLE, when !tx_busy && count > 0: load tx_data ← mem[rd_ptr], pop, go to ISSUE.
  - IDLE, otherwise when !tx_busy && count == 0 && !frame_open && hb_pending: load tx_data ← HB_BYTE, clear hb_pending, go to ISSUE.
  - ISSUE: tx_send = 1 for exactly this cycle; go to GUARD.
  - GUARD: tx_busy is ignored (the transmitter sets busy one cycle late); go to DRAIN.
  - DRAIN: wait for !tx_busy, then go to IDLE.
- **Priority.** Queued response bytes always win over the heartbeat. The heartbeat is never inserted between bytes of an open frame.
- **Reset values.** tx_send=0, tx_data=8'h00, resp_full=0, resp_level=0, ovf=0, hb_pending=0, frame_open=0, state IDLE. Reset mid-transmission discards queued bytes; `uart_tx` is reset by the same rst_n.

## Timing
- Latency: a push sampled at edge E0 into an empty FIFO with tx idle gives tx_send high for the cycle after E1, with tx_data valid from E1.
- Heartbeat latency: hb_tick at E0 with the FIFO empty and tx idle gives tx_send after E2.
- tx_data is held stable from the ISSUE state until the next ISSUE.
- Minimum byte-to-byte spacing: 4 cycles. In practice spacing is bounded by `uart_tx` busy (≈4340 cycles per byte at 115200 baud).
- resp_full and resp_level reflect the registered count: a push at E0 is visible after E0.

## Structure
- The `uart_pkg` shared package holds the state encoding enum and the default HB_BYTE constant.
- The FIFO storage and pointers form one sub-module, `sync_byte_fifo` (DEPTH parameter; push/pop/full/empty/level outputs). This module keeps the frame/heartbeat logic, the FSM and the ovf logic.

## Test plan
- **Single ping.** Push 8'hEE with eof, tx idle → one tx_send with tx_data=8'hEE; resp_level returns to 0.
- **Read frame vs heartbeat.** Push 8'h12 (no eof), fire hb_tick, push 8'h34 (eof) → the tx byte order is 8'h12, 8'h34, 8'hAA; exactly 3 tx_send pulses.
- **Coalescing and disable.**
  - 5 hb_ticks while tx_busy is held high → exactly one 8'hAA after busy falls.
  - hb_en=0 with hb_tick → no send.
- **Overflow.** Push 17 bytes 0..16 with tx_busy stuck high → resp_full=1, ovf=1, only bytes 0..15 are sent once busy is released. ovf_clr then clears ovf.
- **Wrap-around.** Stream 40 bytes while the model drains them with 6-cycle busy → in-order output and no duplicate or lost bytes.
- **Reset mid-operation.** Assert rst_n low with 5 bytes queued during DRAIN → all outputs return to their reset values; after release, no stale bytes are sent.
